// File: rtl/instruction_fetch.sv
// instruction_fetch: issues in-order fetches at pc_in and buffers {pc,data}
// for decode, dropping buffered and in-flight words on a redirect.
// Ports: clk, reset (sync, active-high).
//   pc_in, pc_increment, redirect : program counter side.
//   mem_req_valid/ready/addr      : fetch request to instruction memory.
//   mem_rsp_valid/data            : in-order response from memory.
//   inst_valid/ready/data/pc      : instruction stream to decode.
module instruction_fetch #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_increment,
  input  logic        redirect,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W+1:0] LIMIT =
    (CNT_W+2)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fent_t;

  logic [31:0]      pcq_mem  [DEPTH];
  logic [PW-1:0]    pcq_wr;
  logic [PW-1:0]    pcq_rd;

  fent_t            ibuf_mem [DEPTH];
  logic [PW-1:0]    ibuf_wr;
  logic [PW-1:0]    ibuf_rd;
  logic [CNT_W-1:0] ibuf_cnt;

  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;

  logic [CNT_W+1:0] in_use;
  logic [CNT_W-1:0] in_flight;
  logic             accept;
  logic             rsp_keep;
  logic             rsp_drop;
  logic             pop;
  logic             rsp_sub;
  fent_t            head;

  always_comb begin
    in_use = (CNT_W+2)'(outstanding)
           + (CNT_W+2)'(discard)
           + (CNT_W+2)'(ibuf_cnt);
    in_flight = outstanding + discard;

    // one slot per in-flight or buffered word
    mem_req_valid = ~reset & ~redirect
                  & (in_use < LIMIT);
    accept        = mem_req_valid & mem_req_ready;
    pc_increment  = accept;
    mem_req_addr  = pc_in;

    // stale words are drained before live ones
    rsp_drop = mem_rsp_valid & ~reset
             & ~redirect & (discard != '0);
    rsp_keep = mem_rsp_valid & ~reset
             & ~redirect & (discard == '0)
             & (outstanding != '0);

    // a word landing in a redirect cycle
    // retires one of the in-flight slots
    rsp_sub = mem_rsp_valid
            & (in_flight != '0);

    inst_valid = (ibuf_cnt != '0);
    pop        = inst_valid & inst_ready;
    head       = ibuf_mem[ibuf_rd];
    inst_data  = inst_valid ? head.data : '0;
    inst_pc    = inst_valid ? head.pc : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      ibuf_wr     <= '0;
      ibuf_rd     <= '0;
      ibuf_cnt    <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      ibuf_wr     <= '0;
      ibuf_rd     <= '0;
      ibuf_cnt    <= '0;
      outstanding <= '0;
      discard     <= in_flight
                   - CNT_W'(rsp_sub);
    end else begin
      if (accept)
        pcq_wr <= pcq_wr + PW'(1);
      if (rsp_keep) begin
        pcq_rd  <= pcq_rd + PW'(1);
        ibuf_wr <= ibuf_wr + PW'(1);
      end
      if (pop)
        ibuf_rd <= ibuf_rd + PW'(1);
      outstanding <= outstanding
                   + CNT_W'(accept)
                   - CNT_W'(rsp_keep);
      discard  <= discard - CNT_W'(rsp_drop);
      ibuf_cnt <= ibuf_cnt
                + CNT_W'(rsp_keep)
                - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      pcq_mem[pcq_wr] <= pc_in;
    if (rsp_keep)
      ibuf_mem[ibuf_wr] <= fent_t'{
        pc:   pcq_mem[pcq_rd],
        data: mem_rsp_data
      };
  end

  property p_rsp_tracked;
    @(posedge clk) disable iff (reset)
      mem_rsp_valid |-> (in_flight != '0);
  endproperty

  a_rsp_tracked: assert property (p_rsp_tracked)
    else $error("instruction_fetch: untracked response");

endmodule
